mem_port_responder: RTL

//  Responder (memory-side end) of the mem_* request/done protocol driven by fetch_unit and
//  the load/store unit. Accepts one byte/wyde/tetra/octa read or write and serves it from a
//  64-bit-wide on-chip RAM with byte enables. Handles MMIX big-endian lane alignment and

---
 rtl/mmix_mem_pkg.sv | 23 ++
 rtl/mem_lane_align.sv | 49 ++++
 rtl/mem_port_responder.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mmix_mem_pkg.sv
// Types shared by the MMIX memory initiators (fetch_unit, load/store unit)
// and the memory-side responder.
package mmix_mem_pkg;

    // Access width as encoded on mem_datasize.
    typedef enum logic [1:0] {
        DS_BYTE  = 2'd0,
        DS_WYDE  = 2'd1,
        DS_TETRA = 2'd2,
        DS_OCTA  = 2'd3
    } datasize_t;

    // Right-justified lane mask covering one access of the given width.
    function automatic logic [7:0] size_lanes(input datasize_t size);
        case (size)
            DS_BYTE:  size_lanes = 8'h01;
            DS_WYDE:  size_lanes = 8'h03;
            DS_TETRA: size_lanes = 8'h0f;
            default:  size_lanes = 8'hff;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational MMIX big-endian lane alignment: maps size + byte offset onto
// RAM byte enables, positions store data and extracts load data.
module mem_lane_align
    import mmix_mem_pkg::*;
(
    input  datasize_t   i_size,
    input  logic [2:0]  i_offset,
    input  logic [63:0] i_wdata,
    input  logic [63:0] i_ram_rdata,
    output logic [7:0]  o_byteenable,
    output logic [63:0] o_wdata,
    output logic [63:0] o_rdata
);

    logic [7:0]  w_lanes;
    logic [3:0]  w_nbytes;
    logic [2:0]  w_off;
    logic [2:0]  w_shift;
    logic [5:0]  w_bits;
    logic [63:0] w_dmask;

    // Force the offset to the natural alignment of the size and build the data mask.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        w_off    = i_offset;
        w_nbytes = 4'd1;
        w_dmask  = '0;
        case (i_size)
            DS_BYTE:  begin w_off = i_offset;                w_nbytes = 4'd1; end
            DS_WYDE:  begin w_off = {i_offset[2:1], 1'b0};   w_nbytes = 4'd2; end
            DS_TETRA: begin w_off = {i_offset[2], 2'b00};    w_nbytes = 4'd4; end
            default:  begin w_off = 3'd0;                    w_nbytes = 4'd8; end
        endcase
        for (int i = 0; i < 8; i++) begin
            w_dmask[8*i +: 8] = {8{w_lanes[i]}};
        end
    end

    assign w_lanes = size_lanes(i_size);

    // Byte offset 0 lives in lane 7, so the right-justified value sits (8-off-n) lanes up.
    assign w_shift = 3'(4'd8 - {1'b0, w_off} - w_nbytes);
    assign w_bits  = {w_shift, 3'b000};

    assign o_byteenable = w_lanes << w_shift;
    assign o_wdata      = (i_wdata & w_dmask) << w_bits;
    assign o_rdata      = (i_ram_rdata >> w_bits) & w_dmask;

endmodule

// File: rtl/mem_port_responder.sv
// Memory-side responder of the mem_* request/done protocol. Serves one
// byte/wyde/tetra/octa access from a 64-bit byte-enabled RAM after a
// configurable number of wait states and answers with a one-cycle mem_done.
module mem_port_responder
    import mmix_mem_pkg::*;
#(
    parameter int ADDR_BITS = 13,
    parameter int LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [63:0]          mem_address,
    input  logic [1:0]           mem_datasize,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [63:0]          mem_writedata,
    output logic [63:0]          mem_readdata,
    output logic                 mem_done,
    output logic [ADDR_BITS-1:0] ram_address,
    output logic                 ram_read,
    output logic                 ram_write,
    output logic [7:0]           ram_byteenable,
    output logic [63:0]          ram_writedata,
    input  logic [63:0]          ram_readdata
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_CAPTURE,
        ST_DONE,
        ST_RELEASE
    } state_t;

    // WAIT lasts LATENCY cycles: count LATENCY-1 down to 0.
    localparam logic [3:0] WAIT_LOAD = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [3:0]           r_wait_cnt;
    logic [ADDR_BITS-1:0] r_index;
    logic [2:0]           r_offset;
    datasize_t            r_size;
    logic [63:0]          r_wdata;
    logic                 r_is_read;
    logic                 r_in_range;
    logic [63:0]          r_rdata;

    logic                 w_req;
    logic                 w_in_range;
    logic [7:0]           w_be;
    logic [63:0]          w_wdata_al;
    logic [63:0]          w_rdata_al;

    assign w_req      = mem_read | mem_write;
    assign w_in_range = (mem_address >> (ADDR_BITS + 3)) == 64'd0;

    mem_lane_align u_align (
        .i_size      (r_size),
        .i_offset    (r_offset),
        .i_wdata     (r_wdata),
        .i_ram_rdata (ram_readdata),
        .o_byteenable(w_be),
        .o_wdata     (w_wdata_al),
        .o_rdata     (w_rdata_al)
    );

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state is assigned with <= so every register updates from pre-edge values.
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state and strobe/done decode from the current state.
    always_comb begin
        w_state_nxt    = r_state;
        mem_done       = 1'b0;
        ram_read       = 1'b0;
        ram_write      = 1'b0;
        ram_byteenable = 8'h00;
        ram_writedata  = 64'd0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) w_state_nxt = (LATENCY == 0) ? ST_ACCESS : ST_WAIT;
            end
            ST_WAIT: begin
                if (r_wait_cnt == 4'd0) w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                // Out-of-range accesses keep their timing but never touch the RAM.
                if (r_in_range) begin
                    ram_read       = r_is_read;
                    ram_write      = !r_is_read;
                    ram_byteenable = w_be;
                    ram_writedata  = r_is_read ? 64'd0 : w_wdata_al;
                end
                w_state_nxt = r_is_read ? ST_CAPTURE : ST_DONE;
            end
            ST_CAPTURE: w_state_nxt = ST_DONE;
            ST_DONE: begin
                mem_done    = 1'b1;
                w_state_nxt = ST_RELEASE;
            end
            ST_RELEASE: begin
                // A request still held from the finished transaction is not re-served.
                if (!w_req) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Request capture in IDLE, wait-state counting and load-data capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wait_cnt <= 4'd0;
            r_index    <= '0;
            r_offset   <= 3'd0;
            r_size     <= DS_BYTE;
            r_wdata    <= 64'd0;
            r_is_read  <= 1'b0;
            r_in_range <= 1'b0;
            r_rdata    <= 64'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_index    <= mem_address[ADDR_BITS+2:3];
                        r_offset   <= mem_address[2:0];
                        r_size     <= datasize_t'(mem_datasize);
                        r_wdata    <= mem_writedata;
                        r_is_read  <= mem_read;
                        r_in_range <= w_in_range;
                        r_wait_cnt <= WAIT_LOAD;
                    end
                end
                ST_WAIT:    r_wait_cnt <= r_wait_cnt - 4'd1;
                ST_CAPTURE: r_rdata    <= r_in_range ? w_rdata_al : 64'd0;
                default: ;
            endcase
        end
    end

    assign ram_address  = r_index;
    assign mem_readdata = r_rdata;

endmodule
